// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and widths for the gray_counter / gray_rx family.
// Functions work on a MAX_W-wide container; narrower values are zero-extended, which leaves the decode unchanged.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int TOTAL_W       = 16;
  localparam int MAX_W         = 32;
  localparam int CNT_W         = $clog2(MAX_W + 1);

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// SYNC_STAGES-deep synchronizer for a Gray-coded bus; runs every cycle and flushes to zero on reset.
module gray_sync
  import gray_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_p[i] <= '0;
      end
    end else begin
      sync_p[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  assign dout = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// Receives an asynchronous Gray count, decodes it to binary and reports per-change delta,
// running total and multi-bit-change errors.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [WIDTH-1:0]   gray_in,
  input  logic               err_clear,
  output logic [WIDTH-1:0]   bin_out,
  output logic               bin_valid,
  output logic [WIDTH-1:0]   delta,
  output logic               err_multi,
  output logic               err_sticky,
  output logic [TOTAL_W-1:0] total
);

  logic [WIDTH-1:0] gs;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] delta_n;
  logic [CNT_W-1:0] ham;
  logic             changed;
  logic             multi;

  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] prev_bin;
  logic             primed;

  gray_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (gray_in),
    .dout  (gs)
  );

  // Combinational decode and compare against the last accepted sample
  always_comb begin
    bin     = WIDTH'(gray2bin(MAX_W'(gs)));
    delta_n = bin - prev_bin;
    ham     = popcount(MAX_W'(gs ^ prev_gray));
    changed = enable && primed && (gs != prev_gray);
    multi   = changed && (ham > CNT_W'(1));
  end

  // Register stage: compare state, outputs and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_gray  <= '0;
      prev_bin   <= '0;
      primed     <= 1'b0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      delta      <= '0;
      err_multi  <= 1'b0;
      err_sticky <= 1'b0;
      total      <= '0;
    end else begin
      bin_valid <= changed;
      err_multi <= multi;
      if (multi) begin
        err_sticky <= 1'b1;
      end else if (err_clear) begin
        err_sticky <= 1'b0;
      end

      if (!enable) begin
        primed <= 1'b0;
      end else if (!primed) begin
        prev_gray <= gs;
        prev_bin  <= bin;
        primed    <= 1'b1;
      end else if (changed) begin
        prev_gray <= gs;
        prev_bin  <= bin;
        bin_out   <= bin;
        delta     <= delta_n;
        total     <= total + TOTAL_W'(delta_n);
      end
    end
  end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder (WIDTH 8, SYNC_STAGES 2).
module tb_gray_rx_decoder;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  gray_in;
  logic        err_clear;
  logic [7:0]  bin_out;
  logic        bin_valid;
  logic [7:0]  delta;
  logic        err_multi;
  logic        err_sticky;
  logic [15:0] total;

  int checks = 0;
  int errors = 0;

  int         pulses;
  int         cap_err;
  int         stray_err;
  logic [7:0] cap_bin;
  logic [7:0] cap_delta;

  gray_rx_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .gray_in    (gray_in),
    .err_clear  (err_clear),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .delta      (delta),
    .err_multi  (err_multi),
    .err_sticky (err_sticky),
    .total      (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_caps();
    pulses = 0; cap_err = 0; stray_err = 0; cap_bin = 8'hxx; cap_delta = 8'hxx;
  endtask

  // Drive a gray value at a falling edge and observe n following cycles.
  task automatic apply(input logic [7:0] g, input int n);
    gray_in = g;
    repeat (n) begin
      @(negedge clk);
      if (bin_valid) begin
        pulses++;
        cap_bin   = bin_out;
        cap_delta = delta;
        if (err_multi) cap_err++;
      end else if (err_multi) begin
        stray_err++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; gray_in = 8'h00; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bin_out !== 8'h00) begin errors++; $display("FAIL rst_bin_out got %h exp 00", bin_out); end
    checks++; if (bin_valid !== 1'b0) begin errors++; $display("FAIL rst_bin_valid got %b exp 0", bin_valid); end
    checks++; if (total !== 16'h0000) begin errors++; $display("FAIL rst_total got %h exp 0000", total); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL rst_err_sticky got %b exp 0", err_sticky); end
    reset = 1'b0;
  endtask

  task automatic test_basic_count();
    clear_caps();
    apply(8'h00, 4);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL prime_no_pulse got %0d exp 0", pulses); end
    apply(8'h01, 4);
    checks++; if (cap_bin !== 8'd1 || cap_delta !== 8'd1) begin errors++; $display("FAIL step1 got bin %h delta %h exp 01 01", cap_bin, cap_delta); end
    apply(8'h03, 4);
    checks++; if (cap_bin !== 8'd2 || cap_delta !== 8'd1) begin errors++; $display("FAIL step2 got bin %h delta %h exp 02 01", cap_bin, cap_delta); end
    apply(8'h02, 4);
    checks++; if (cap_bin !== 8'd3 || cap_delta !== 8'd1) begin errors++; $display("FAIL step3 got bin %h delta %h exp 03 01", cap_bin, cap_delta); end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL basic_pulses got %0d exp 3", pulses); end
    checks++; if (total !== 16'd3) begin errors++; $display("FAIL basic_total got %0d exp 3", total); end
    checks++; if (err_sticky !== 1'b0 || cap_err + stray_err !== 0) begin errors++; $display("FAIL basic_err got sticky %b errs %0d exp 0 0", err_sticky, cap_err + stray_err); end
  endtask

  task automatic test_wrap();
    clear_caps();
    enable = 1'b0;
    apply(8'h80, 4);
    enable = 1'b1;
    apply(8'h80, 4);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL wrap_reprime got %0d pulses exp 0", pulses); end
    apply(8'h00, 4);
    checks++; if (pulses !== 1 || cap_bin !== 8'h00 || cap_delta !== 8'h01) begin errors++; $display("FAIL wrap got pulses %0d bin %h delta %h exp 1 00 01", pulses, cap_bin, cap_delta); end
    checks++; if (cap_err + stray_err !== 0) begin errors++; $display("FAIL wrap_err got %0d exp 0", cap_err + stray_err); end
    checks++; if (total !== 16'd4) begin errors++; $display("FAIL wrap_total got %0d exp 4", total); end
  endtask

  task automatic test_multi_jump();
    clear_caps();
    enable = 1'b0;
    apply(8'h02, 4);
    enable = 1'b1;
    apply(8'h02, 4);
    apply(8'h05, 4);
    checks++; if (pulses !== 1 || cap_err !== 1 || stray_err !== 0) begin errors++; $display("FAIL multi_pulse got valid %0d aligned_err %0d stray %0d exp 1 1 0", pulses, cap_err, stray_err); end
    checks++; if (cap_bin !== 8'd6 || cap_delta !== 8'd3) begin errors++; $display("FAIL multi_val got bin %h delta %h exp 06 03", cap_bin, cap_delta); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL multi_sticky got %b exp 1", err_sticky); end
    checks++; if (total !== 16'd7) begin errors++; $display("FAIL multi_total got %0d exp 7", total); end
  endtask

  task automatic test_disabled_motion();
    clear_caps();
    enable = 1'b0;
    apply(8'h02, 4);
    apply(8'h07, 4);
    enable = 1'b1;
    apply(8'h07, 4);
    checks++; if (pulses !== 0 || stray_err !== 0) begin errors++; $display("FAIL disabled got pulses %0d errs %0d exp 0 0", pulses, stray_err); end
    checks++; if (err_sticky !== 1'b1 || total !== 16'd7) begin errors++; $display("FAIL disabled_hold got sticky %b total %0d exp 1 7", err_sticky, total); end
    apply(8'h05, 4);
    checks++; if (cap_bin !== 8'd6 || cap_delta !== 8'd1 || total !== 16'd8) begin errors++; $display("FAIL fwd got bin %h delta %h total %0d exp 06 01 8", cap_bin, cap_delta, total); end
    apply(8'h07, 4);
    checks++; if (cap_bin !== 8'd5 || cap_delta !== 8'hFF || total !== 16'd263) begin errors++; $display("FAIL back got bin %h delta %h total %0d exp 05 ff 263", cap_bin, cap_delta, total); end
  endtask

  task automatic test_err_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clear got %b exp 0", err_sticky); end
    // Gray 0x07 -> 0x00 is a 3-bit jump; detection lands two edges after first sample.
    gray_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bin_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b exp 0", bin_valid); end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++; if (bin_valid !== 1'b1 || err_multi !== 1'b1) begin errors++; $display("FAIL latency got valid %b multi %b exp 1 1", bin_valid, err_multi); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", err_sticky); end
    checks++; if (bin_out !== 8'h00 || delta !== 8'hFB || total !== 16'h0202) begin errors++; $display("FAIL clr_jump got bin %h delta %h total %h exp 00 fb 0202", bin_out, delta, total); end
    @(negedge clk);
    checks++; if (bin_valid !== 1'b0 || err_multi !== 1'b0) begin errors++; $display("FAIL one_cycle got valid %b multi %b exp 0 0", bin_valid, err_multi); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bin_out !== 8'h00 || delta !== 8'h00 || total !== 16'h0000) begin errors++; $display("FAIL midrst_data got bin %h delta %h total %h exp 0 0 0", bin_out, delta, total); end
    checks++; if (err_sticky !== 1'b0 || bin_valid !== 1'b0 || err_multi !== 1'b0) begin errors++; $display("FAIL midrst_flags got %b%b%b exp 000", err_sticky, bin_valid, err_multi); end
    clear_caps();
    apply(8'h00, 6);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_prime got %0d exp 0", pulses); end
    apply(8'h01, 4);
    checks++; if (pulses !== 1 || cap_bin !== 8'd1 || total !== 16'd1) begin errors++; $display("FAIL midrst_step got pulses %0d bin %h total %0d exp 1 01 1", pulses, cap_bin, total); end
  endtask

  task automatic test_total_wrap();
    // Each 1->0->1 round trip adds 255+1; 256 of them wrap the 16-bit total back to its start.
    clear_caps();
    for (int i = 0; i < 256; i++) begin
      apply(8'h00, 3);
      apply(8'h01, 3);
    end
    checks++; if (pulses !== 512) begin errors++; $display("FAIL wrap16_pulses got %0d exp 512", pulses); end
    checks++; if (total !== 16'd1) begin errors++; $display("FAIL wrap16_total got %0d exp 1", total); end
    apply(8'h00, 3);
    checks++; if (total !== 16'd256 || cap_delta !== 8'hFF) begin errors++; $display("FAIL wrap16_next got total %0d delta %h exp 256 ff", total, cap_delta); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; gray_in = 8'h00; err_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_count();
    test_wrap();
    test_multi_jump();
    test_disabled_motion();
    test_err_clear();
    test_mid_reset();
    test_total_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
